// File: rtl/alu_serial_resp.sv
// -----------------------------------------------------------------------------
// alu_serial_resp
//   Bit-serial (slice-serial) 32-bit ALU with a valid/ready request channel and
//   a valid/ready response channel. An accepted operation is processed
//   SLICE_W bits per cycle, LSB slice first, so BUSY lasts 32/SLICE_W cycles.
//   The result, zero and err outputs are registered. They change only when an
//   operation completes, and they hold across IDLE.
//
// Ports
//   clk        : clock, rising edge
//   resetn     : asynchronous active-low reset
//   req_valid  : request presented
//   req_ready  : block idle, can accept a request
//   a, b       : 32-bit two's complement operands
//   op         : 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (others unsupported)
//   rsp_valid  : result available
//   rsp_ready  : initiator consumes result
//   z          : result
//   zero       : z == 0
//   err        : accepted op was unsupported
// -----------------------------------------------------------------------------
module alu_serial_resp #(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] z,
  output logic        zero,
  output logic        err
);

  localparam int N = 32 / SLICE_W;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;       // holds ~b for SUB/SLT so one adder serves all ops
  logic [2:0]  op_q;
  logic [5:0]  cnt_q;
  logic        carry_q;
  logic [31:0] acc_q;     // working result, built one slice per cycle
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] z_q;
  logic        zero_q;
  logic        err_q;

  logic [SLICE_W-1:0] a_sl_d;
  logic [SLICE_W-1:0] b_sl_d;
  logic [SLICE_W:0]   sum_sl_d;
  logic [SLICE_W-1:0] res_sl_d;
  logic [31:0]        acc_d;
  logic [31:0]        z_d;
  logic               slt_d;
  logic               err_d;
  logic               last_d;
  logic               sub_req_d;

  // Slice datapath
  always_comb begin
    a_sl_d   = a_q[cnt_q*SLICE_W +: SLICE_W];
    b_sl_d   = b_q[cnt_q*SLICE_W +: SLICE_W];
    sum_sl_d = {1'b0, a_sl_d} + {1'b0, b_sl_d} + {{SLICE_W{1'b0}}, carry_q};

    case (op_q)
      OP_AND:                 res_sl_d = a_sl_d & b_sl_d;
      OP_OR:                  res_sl_d = a_sl_d | b_sl_d;
      OP_ADD, OP_SUB, OP_SLT: res_sl_d = sum_sl_d[SLICE_W-1:0];
      default:                res_sl_d = '0;
    endcase

    acc_d = acc_q;
    acc_d[cnt_q*SLICE_W +: SLICE_W] = res_sl_d;

    // Signed less-than: with differing signs, a < b exactly when a is
    // negative; with equal signs the difference cannot overflow, so its sign
    // decides. b_q holds ~b here, so equal stored MSBs mean opposite signs.
    if (a_q[31] == b_q[31]) slt_d = a_q[31];
    else                    slt_d = sum_sl_d[SLICE_W-1];

    err_d = 1'b0;
    case (op_q)
      OP_AND, OP_OR, OP_ADD, OP_SUB: z_d = acc_d;
      OP_SLT:                        z_d = {31'b0, slt_d};
      default: begin
        z_d   = '0;
        err_d = 1'b1;
      end
    endcase

    last_d    = (cnt_q == 6'(N - 1));
    sub_req_d = (op == OP_SUB) || (op == OP_SLT);
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      z_q         <= '0;
      zero_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q         <= a;
            b_q         <= sub_req_d ? ~b : b;
            op_q        <= op;
            cnt_q       <= '0;
            carry_q     <= sub_req_d;  // +1 completes a + ~b + 1
            acc_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          acc_q   <= acc_d;
          carry_q <= sum_sl_d[SLICE_W];
          cnt_q   <= cnt_q + 6'd1;
          if (last_d) begin
            // Final carry-out is dropped: arithmetic wraps modulo 2^32.
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            z_q         <= z_d;
            zero_q      <= (z_d == 32'd0);
            err_q       <= err_d;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign z         = z_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_serial_resp.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_resp
//   Directed and random checks of alu_serial_resp at SLICE_W = 8, 1 and 32.
//   Instance 0: SLICE_W=8 (latency 4), 1: SLICE_W=1 (32), 2: SLICE_W=32 (1).
// -----------------------------------------------------------------------------
module tb_alu_serial_resp;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        req_valid [3];
  logic        rsp_ready [3];
  logic        req_ready_w [3];
  logic        rsp_valid_w [3];
  logic [31:0] z_w [3];
  logic        zero_w [3];
  logic        err_w [3];

  int errors = 0;
  int checks = 0;
  int lat_tab [3] = '{4, 32, 1};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int SW = (gi == 0) ? 8 : (gi == 1) ? 1 : 32;
    alu_serial_resp #(.SLICE_W(SW)) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid[gi]),
      .req_ready (req_ready_w[gi]),
      .a         (a),
      .b         (b),
      .op        (op),
      .rsp_valid (rsp_valid_w[gi]),
      .rsp_ready (rsp_ready[gi]),
      .z         (z_w[gi]),
      .zero      (zero_w[gi]),
      .err       (err_w[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural reference: {err, z}
  function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [2:0] mop);
    case (mop)
      3'b000:  return {1'b0, ma & mb};
      3'b001:  return {1'b0, ma | mb};
      3'b010:  return {1'b0, ma + mb};
      3'b110:  return {1'b0, ma - mb};
      3'b111:  return {1'b0, 31'b0, ($signed(ma) < $signed(mb))};
      default: return {1'b1, 32'b0};
    endcase
  endfunction

  // Waits (bounded) for rsp_valid; returns number of edges seen.
  task automatic wait_rsp(input int inst, output int cyc);
    cyc = 0;
    while (!rsp_valid_w[inst] && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake(input int inst);
    @(negedge clk);
    rsp_ready[inst] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[inst] = 1'b0;
  endtask

  task automatic run_op(input int inst, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [2:0] top, input string tag);
    logic [32:0] m;
    int cyc;
    m = model(ta, tb_v, top);
    @(negedge clk);
    check({tag, ":req_ready"}, 32'(req_ready_w[inst]), 32'd1);
    a = ta; b = tb_v; op = top;
    req_valid[inst] = 1'b1;
    @(posedge clk); #1;
    req_valid[inst] = 1'b0;
    // Scramble operands after accept; the DUT must ignore them.
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    wait_rsp(inst, cyc);
    check({tag, ":latency"}, 32'(cyc), 32'(lat_tab[inst]));
    check({tag, ":z"}, z_w[inst], m[31:0]);
    check({tag, ":zero"}, 32'(zero_w[inst]), 32'(m[31:0] == 32'd0));
    check({tag, ":err"}, 32'(err_w[inst]), 32'(m[32]));
    $display("txn %s inst=%0d a=%08h b=%08h op=%03b z=%08h zero=%0b err=%0b lat=%0d",
             tag, inst, ta, tb_v, top, z_w[inst], zero_w[inst], err_w[inst], cyc);
    handshake(inst);
    check({tag, ":rsp_valid_low"}, 32'(rsp_valid_w[inst]), 32'd0);
  endtask

  initial begin
    int cyc;
    logic seen;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      rsp_ready[i] = 1'b0;
    end

    // Reset state
    #12;
    for (int i = 0; i < 3; i++) begin
      check("rst:req_ready", 32'(req_ready_w[i]), 32'd1);
      check("rst:rsp_valid", 32'(rsp_valid_w[i]), 32'd0);
      check("rst:z", z_w[i], 32'd0);
      check("rst:zero", 32'(zero_w[i]), 32'd1);
      check("rst:err", 32'(err_w[i]), 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;

    // Directed vectors on every slice width
    for (int i = 0; i < 3; i++) begin
      run_op(i, 32'h0000_00FF, 32'h0000_0001, 3'b010, "add_carry");
      run_op(i, 32'h1234_5678, 32'h1234_5678, 3'b110, "sub_eq");
      run_op(i, 32'h1234_5678, 32'h1234_5678, 3'b000, "and_same");
      run_op(i, 32'h1234_5678, 32'h1234_5678, 3'b001, "or_same");
      run_op(i, 32'h8000_0000, 32'h0000_0001, 3'b111, "slt_neg");
      run_op(i, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b111, "slt_pos");
      run_op(i, 32'h8000_0000, 32'h7FFF_FFFF, 3'b111, "slt_ovf");
      run_op(i, 32'hFFFF_FFFF, 32'h0000_0001, 3'b010, "add_wrap");
      run_op(i, 32'h0000_0000, 32'h0000_0001, 3'b110, "sub_wrap");
      run_op(i, 32'hDEAD_BEEF, 32'h1234_5678, 3'b011, "unsup");
      run_op(i, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, "and_clr_err");
    end

    // z/zero/err hold while idle
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold:z", z_w[0], 32'h00F0_00F0);

    // Backpressure on instance 0
    @(negedge clk);
    a = 32'd1; b = 32'd2; op = 3'b010;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    a = 32'd100; b = 32'd200; op = 3'b010;
    wait_rsp(0, cyc);
    check("bp:latency", 32'(cyc), 32'd4);
    check("bp:z", z_w[0], 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp:z_stable", z_w[0], 32'd3);
      check("bp:req_ready", 32'(req_ready_w[0]), 32'd0);
      check("bp:rsp_valid", 32'(rsp_valid_w[0]), 32'd1);
    end
    handshake(0);
    check("bp:idle_ready", 32'(req_ready_w[0]), 32'd1);
    check("bp:idle_valid", 32'(rsp_valid_w[0]), 32'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("bp:accept2", 32'(req_ready_w[0]), 32'd0);
    wait_rsp(0, cyc);
    check("bp:latency2", 32'(cyc), 32'd4);
    check("bp:z2", z_w[0], 32'd300);
    $display("txn backpressure z=%08h", z_w[0]);
    handshake(0);

    // Reset abort in BUSY cycle 2 (instance 0)
    @(negedge clk);
    a = 32'h0000_0005; b = 32'h0000_0007; op = 3'b010;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check("abort:req_ready", 32'(req_ready_w[0]), 32'd1);
    check("abort:rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
    check("abort:z", z_w[0], 32'd0);
    check("abort:zero", 32'(zero_w[0]), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid_w[0];
    end
    check("abort:no_rsp", 32'(seen), 32'd0);
    $display("txn reset_abort");
    run_op(0, 32'h0000_0005, 32'h0000_0007, 3'b010, "after_abort");

    // Random operations against the model
    for (int n = 0; n < 1000; n++)
      run_op(0, $urandom, $urandom, 3'($urandom_range(0, 7)), "rand8");
    for (int n = 0; n < 150; n++)
      run_op(1, $urandom, $urandom, 3'($urandom_range(0, 7)), "rand1");
    for (int n = 0; n < 200; n++)
      run_op(2, $urandom, $urandom, 3'($urandom_range(0, 7)), "rand32");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
